// File: rtl/demux2_router.sv
// 1-to-2 stream demultiplexer with per-output FIFOs.
// Steers each input word to A, B, or both (multicast).
module demux2_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic [CW-1:0]    count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             pop;

  assign valid = (count != '0);
  assign pop   = valid && ready;
  assign data  = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end
endmodule

module demux2_router #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_bcast,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] b_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [CW-1:0]    a_count,
  output logic [CW-1:0]    b_count
);
  logic a_space;
  logic b_space;
  logic accept;
  logic push_a;
  logic push_b;

  // Space comes from registered counts only: no ready-to-ready path.
  assign a_space = (a_count < CW'(DEPTH));
  assign b_space = (b_count < CW'(DEPTH));

  always_comb begin
    in_ready = b_space;
    if (in_bcast) begin
      in_ready = a_space && b_space;
    end else if (in_sel) begin
      in_ready = a_space;
    end
  end

  assign accept = in_valid && in_ready;
  assign push_a = accept && (in_bcast || in_sel);
  assign push_b = accept && (in_bcast || !in_sel);

  demux2_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .CW   (CW)
  ) u_fifo_a (
    .clk      (clk),
    .reset    (reset),
    .push     (push_a),
    .push_data(in_data),
    .ready    (a_ready),
    .data     (a_data),
    .valid    (a_valid),
    .count    (a_count)
  );

  demux2_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .CW   (CW)
  ) u_fifo_b (
    .clk      (clk),
    .reset    (reset),
    .push     (push_b),
    .push_data(in_data),
    .ready    (b_ready),
    .data     (b_data),
    .valid    (b_valid),
    .count    (b_count)
  );
endmodule
